// File: rtl/load_store_unit_pkg.sv
// Shared core definitions: ALU control codes, load/store funct3
// codes, LSU state enum and byte-lane helper functions.
package load_store_unit_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_t;

  // Illegal size code or misaligned address for the access kind.
  function automatic logic is_exc(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    logic mis;
    if (we) bad = (f3 >= 3'd3);
    else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    mis = ((f3[1:0] == 2'b01) && off[0]) ||
          ((f3[1:0] == 2'b10) && (off != 2'b00));
    return bad || mis;
  endfunction

  // Size is in f3[1:0] for both signed and unsigned loads.
  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend: picks the byte/half addressed by addr[1:0] from the
// bus word and sign/zero extends it. in: funct3, addr, bus_rdata; out: result.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] bus_rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = bus_rdata[{addr, 3'b000} +: 8];
    h      = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    result = bus_rdata;
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_BU:   result = {24'd0, b};
      F3_HU:   result = {16'd0, h};
      default: result = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: IDLE/ACCESS/DONE bus sequencer for loads and stores.
// Ports: core side (mem_read/write, funct3, addr, wdata, rdata, stall,
// done, addr_exc, bus_err) and a req/ready word bus with byte enables.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        addr_exc,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [31:0]   ext;
  logic          start;
  logic          exc;
  logic          go;

  // Store wins when both strobes are high, so exc checks the store rules.
  assign start    = mem_read | mem_write;
  assign exc      = is_exc(mem_write, funct3, addr[1:0]);
  assign addr_exc = (state == IDLE) && start && exc;
  assign go       = (state == IDLE) && start && !exc;
  assign stall    = go || (state == ACCESS);

  load_extend u_ext (
    .funct3    (f3_q),
    .addr      (off_q),
    .bus_rdata (bus_rdata),
    .result    (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done    <= 1'b0;
          bus_err <= 1'b0;
          if (go) begin
            state     <= ACCESS;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= lane_mask(funct3, addr[1:0]);
            bus_wdata <= lane_data(funct3, wdata);
            f3_q      <= funct3;
            off_q     <= addr[1:0];
          end
        end
        ACCESS: begin
          if (bus_ready) begin
            state   <= DONE;
            done    <= 1'b1;
            rdata   <= bus_we ? 32'd0 : ext;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
          end else if (cnt == LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            rdata   <= '0;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          bus_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected load results are
// queued at issue and popped on each done pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        addr_exc;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  load_store_unit #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .addr_exc  (addr_exc),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rdata", rdata, e.rd);
        check("sb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
      end
    end
  end

  task automatic run_txn(
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rbus,
    input int          dly,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input logic [31:0] erd,
    input logic        eerr,
    input int          eacc
  );
    int k;
    int edges;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    check("stall_start", {31'd0, stall}, 32'd1);
    check("exc_start", {31'd0, addr_exc}, 32'd0);
    sb.push_back('{erd, eerr});
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'd7;
    addr      = 32'hDEAD_BEEF;
    wdata     = 32'h5555_5555;
    edges = 1;
    k = 0;
    while (!done && k < 40) begin
      bus_ready = (dly >= 0) && (k >= dly);
      bus_rdata = rbus;
      @(negedge clk);
      check("bus_req", {31'd0, bus_req}, 32'd1);
      check("bus_addr", bus_addr, {a[31:2], 2'b00});
      check("bus_be", {28'd0, bus_be}, {28'd0, ebe});
      check("bus_wdata", bus_wdata, ewd);
      check("bus_we", {31'd0, bus_we}, {31'd0, wr});
      check("stall_acc", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      edges++;
      k++;
    end
    bus_ready = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    check("done_seen", {31'd0, done}, 32'd1);
    check("acc_cycles", k, eacc);
    check("latency", edges, eacc + 1);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("req_done", {31'd0, bus_req}, 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("err_clr", {31'd0, bus_err}, 32'd0);
  endtask

  task automatic exc_case(
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a
  );
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("exc_flag", {31'd0, addr_exc}, 32'd1);
      check("exc_stall", {31'd0, stall}, 32'd0);
      check("exc_req", {31'd0, bus_req}, 32'd0);
      @(posedge clk);
      #1;
      check("exc_req_edge", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("exc_clear", {31'd0, addr_exc}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, bus_err}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_we", {31'd0, bus_we}, 32'd0);
    check("rst_be", {28'd0, bus_be}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // LB, byte 3, sign bit set
    run_txn(1, 0, 3'd0, 32'h103, 0, 32'h80FF_1234, 0,
            4'b1000, 0, 32'hFFFF_FF80, 0, 1);
    // SH, ready after three wait cycles
    run_txn(0, 1, 3'd1, 32'h202, 32'h0000_BEEF, 0, 3,
            4'b1100, 32'hBEEF_BEEF, 0, 0, 4);
    exc_case(1, 0, 3'd2, 32'h101);
    exc_case(0, 1, 3'd3, 32'h100);
    exc_case(1, 0, 3'd5, 32'h201);
    // LHU with no ready: timeout
    run_txn(1, 0, 3'd5, 32'h0, 0, 32'hFFFF_FFFF, -1,
            4'b0011, 0, 0, 1, 16);

    // SW aborted by reset in its second ACCESS cycle
    @(negedge clk);
    mem_write = 1'b1;
    funct3    = 3'd2;
    addr      = 32'h300;
    wdata     = 32'h1111_2222;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    check("abort_req1", {31'd0, bus_req}, 32'd1);
    @(posedge clk);
    #1;
    check("abort_req2", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_req", {31'd0, bus_req}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_nodone", {31'd0, done}, 32'd0);

    run_txn(1, 0, 3'd2, 32'h400, 0, 32'h1234_5678, 0,
            4'b1111, 0, 32'h1234_5678, 0, 1);
    run_txn(1, 0, 3'd4, 32'h501, 0, 32'h0000_9A00, 1,
            4'b0010, 0, 32'h0000_009A, 0, 2);
    run_txn(1, 0, 3'd1, 32'h602, 0, 32'h8001_0000, 2,
            4'b1100, 0, 32'hFFFF_8001, 0, 3);
    // Both strobes high: store wins
    run_txn(1, 1, 3'd0, 32'h703, 32'h1234_56A5, 32'hFFFF_FFFF, 0,
            4'b1000, 32'hA5A5_A5A5, 0, 0, 1);
    run_txn(0, 1, 3'd2, 32'h800, 32'hCAFE_F00D, 0, 0,
            4'b1111, 32'hCAFE_F00D, 0, 0, 1);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: maximum ACCESS cycles without bus_ready before abort.
REQ-002 SHALL have port clk, in, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-004 SHALL have port mem_read, in, 1: the current instruction is a load.
REQ-005 SHALL have port mem_write, in, 1: the current instruction is a store.
REQ-006 SHALL have port funct3, in, 3: size/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-007 SHALL have port addr, in, 32: effective byte address, equal to ALU_Result.
REQ-008 SHALL have port wdata, in, 32: store data (rs2).
REQ-009 SHALL have port rdata, out, 32: extended load result, valid while done=1.
REQ-010 SHALL have port stall, out, 1: core pipeline hold request.
REQ-011 SHALL have port done, out, 1: one-cycle completion pulse.
REQ-012 SHALL have port addr_exc, out, 1: misaligned address or illegal funct3.
REQ-013 SHALL have port bus_err, out, 1: timeout abort, valid with done.
REQ-014 SHALL have bus ports bus_req out 1, bus_we out 1, bus_addr out 32 (word-aligned), bus_be out 4, bus_wdata out 32, bus_ready in 1, bus_rdata in 32.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-016 IDLE: start = mem_read|mem_write; if start and no exception, latch addr/funct3/wdata/we and go to ACCESS at the next edge.
REQ-017 mem_write SHALL take priority when mem_read and mem_write are both high (store performed).
REQ-018 addr_exc SHALL be combinational in IDLE: halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 in {3,6,7} for loads / >=3 for stores; on exc there is no bus access, stall=0, state stays IDLE.
REQ-019 stall SHALL equal (IDLE and start and not addr_exc) or ACCESS; 0 in DONE.
REQ-020 ACCESS: bus_req=1, bus_addr={addr[31:2],2'b00}, bus_we=latched we; all held stable until bus_ready=1 is sampled.
REQ-021 bus_be SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, 4'b1111 for word; the same rule applies to loads.
REQ-022 bus_wdata SHALL replicate the byte x4 for SB, the half x2 for SH, and pass the word for SW.
REQ-023 On bus_ready in ACCESS: capture the extended bus_rdata into rdata (loads), go to DONE.
REQ-024 Load extraction: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through; stores set rdata=0.
REQ-025 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without bus_ready; at TIMEOUT_CYC-1 without ready, go to DONE with bus_err=1, rdata=0, bus_req dropped.
REQ-026 DONE: done=1 for exactly one cycle, then unconditionally go to IDLE; bus_err cleared on leaving DONE.
REQ-027 Inputs SHALL be ignored outside IDLE; the latency from start to done is 2 cycles with bus_ready already high.
REQ-028 bus_ready outside ACCESS SHALL be ignored.

Reset
REQ-029 reset SHALL force state=IDLE, counter=0, rdata=0, done=0, bus_err=0, bus_req=0, bus_we=0, bus_be=0.
REQ-030 reset mid-ACCESS SHALL drop bus_req at that edge with no done pulse, and the transaction is abandoned.

Structure
REQ-031 funct3 load/store codes and the FSM state enum SHALL live in the shared define.sv alongside the ALU control codes.
REQ-032 Load extraction SHALL be one combinational sub-module, load_extend (in: funct3, addr[1:0], bus_rdata; out: 32-bit result).
REQ-033 The top level SHALL contain the FSM, latches, counter, and store byte-lane logic.

Verification
REQ-034 LB addr=0x103, bus_rdata=0x80FF_1234, ready immediate -> bus_be=1000, rdata=0xFFFF_FF80, done 2 cycles after start.
REQ-035 SH addr=0x202, wdata=0x0000_BEEF, ready after 3 cycles -> bus_be=1100, bus_wdata=0xBEEF_BEEF held stable 4 cycles, stall high throughout.
REQ-036 LW addr=0x101 -> addr_exc=1 same cycle, bus_req never rises, stall=0.
REQ-037 LHU addr=0x0, bus_ready held 0 -> bus_err=1 and done after 16 ACCESS cycles, rdata=0.
REQ-038 reset asserted in the 2nd ACCESS cycle of an SW -> bus_req=0 next cycle, no done, next LW proceeds normally.
